instruction_fetch_aligner: RTL and testbench



---
 rtl/instruction_fetch_aligner.sv | 136 +++++++++++++
 tb/tb_instruction_fetch_aligner.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_aligner.sv
// Re-slices 32-bit fetched words into 16/32-bit instructions with their PCs.
// Optional feature macro: ALIGNER_COMPRESSED_EN (undefined = 1-word pass-through).
module instruction_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] fetchWord,
    input  logic        fetchValid,
    output logic        fetchReady,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic        instrValid,
    input  logic        instrReady
);

`ifdef ALIGNER_COMPRESSED_EN

    logic [47:0] buffer;
    logic [1:0]  count;
    logic        skipHalf;
    logic [31:0] pc;

    logic [15:0] half0;
    logic [15:0] half1;
    logic        isComp;
    logic        canEmit;
    logic        xfer;
    logic        accept;
    logic [1:0]  consumed;
    logic [1:0]  remaining;
    logic [47:0] shifted;
    logic [47:0] bufferNext;
    logic [1:0]  countNext;
    logic        unusedBits;

    assign unusedBits = redirectPc[0];

    assign half0   = buffer[15:0];
    assign half1   = buffer[31:16];
    assign isComp  = (half0[1:0] != 2'b11);
    // A 32-bit instruction with only its low half buffered waits for the next word.
    assign canEmit = isComp ? (count >= 2'd1) : (count >= 2'd2);

    assign instrValid = !redirectValid && canEmit;
    assign xfer       = instrValid && instrReady;
    assign consumed   = !xfer ? 2'd0 : (isComp ? 2'd1 : 2'd2);
    assign remaining  = count - consumed;
    assign fetchReady = !redirectValid && (remaining <= 2'd1);
    assign accept     = fetchValid && fetchReady;

    assign instr   = isComp ? {16'h0000, half0} : {half1, half0};
    assign instrPc = pc;

    always_comb begin
        unique case (consumed)
            2'd1:    shifted = {16'h0000, buffer[47:16]};
            2'd2:    shifted = {32'h0000_0000, buffer[47:32]};
            default: shifted = buffer;
        endcase
        bufferNext = shifted;
        countNext  = remaining;
        if (accept) begin
            if (skipHalf) begin
                if (remaining == 2'd0) bufferNext[15:0]  = fetchWord[31:16];
                else                   bufferNext[31:16] = fetchWord[31:16];
                countNext = remaining + 2'd1;
            end else begin
                if (remaining == 2'd0) bufferNext[31:0]  = fetchWord;
                else                   bufferNext[47:16] = fetchWord;
                countNext = remaining + 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            buffer   <= '0;
            count    <= 2'd0;
            skipHalf <= 1'b0;
            pc       <= {RESET_PC[31:1], 1'b0};
        end else if (redirectValid) begin
            count    <= 2'd0;
            skipHalf <= redirectPc[1];
            pc       <= {redirectPc[31:1], 1'b0};
        end else begin
            buffer <= bufferNext;
            count  <= countNext;
            if (accept) skipHalf <= 1'b0;
            if (xfer)   pc <= pc + (isComp ? 32'd2 : 32'd4);
        end
    end

`else

    logic [31:0] wordBuf;
    logic        full;
    logic [31:0] pc;
    logic        xfer;
    logic        accept;
    logic [1:0]  unusedBits;

    assign unusedBits = redirectPc[1:0];

    assign instrValid = !redirectValid && full;
    assign xfer       = instrValid && instrReady;
    assign fetchReady = !redirectValid && (!full || instrReady);
    assign accept     = fetchValid && fetchReady;

    assign instr   = wordBuf;
    assign instrPc = pc;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wordBuf <= '0;
            full    <= 1'b0;
            pc      <= {RESET_PC[31:2], 2'b00};
        end else if (redirectValid) begin
            full <= 1'b0;
            pc   <= {redirectPc[31:2], 2'b00};
        end else begin
            if (accept) begin
                wordBuf <= fetchWord;
                full    <= 1'b1;
            end else if (xfer) begin
                full <= 1'b0;
            end
            if (xfer) pc <= pc + 32'd4;
        end
    end

`endif

endmodule

// File: tb/tb_instruction_fetch_aligner.sv
// Scoreboard bench for instruction_fetch_aligner; expectations follow ALIGNER_COMPRESSED_EN.
module tb_instruction_fetch_aligner;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] fetchWord;
    logic        fetchValid;
    logic        fetchReady;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrValid;
    logic        instrReady;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    instruction_fetch_aligner #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rstN(rstN),
        .fetchWord(fetchWord), .fetchValid(fetchValid), .fetchReady(fetchReady),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .instr(instr), .instrPc(instrPc), .instrValid(instrValid), .instrReady(instrReady)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
    exp_t expQ[$];
    int   xferLog[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    always @(posedge clk) cycle++;

    // Output transfers are observed mid-cycle and checked against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rstN && instrValid && instrReady) begin
            xferLog.push_back(cycle);
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_instr: got instr=%h pc=%h, required no transfer", instr, instrPc);
            end else begin
                e = expQ.pop_front();
                if (instr !== e.instr || instrPc !== e.pc) begin
                    bad++;
                    $display("FAIL instr_out: got instr=%h pc=%h, required instr=%h pc=%h",
                             instr, instrPc, e.instr, e.pc);
                end
            end
        end
    end

    task automatic pushExp(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        expQ.push_back(e);
    endtask

    task automatic sendWord(input logic [31:0] w);
        int n = 0;
        fetchValid = 1'b1;
        fetchWord  = w;
        @(negedge clk);
        while (!fetchReady && n < 50) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (fetchReady !== 1'b1) begin
            bad++;
            $display("FAIL fetch_accept: word %h not accepted within 50 cycles", w);
        end
        @(posedge clk);
        #1;
        fetchValid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d instrs pending, required 0", name, expQ.size());
        end
    endtask

    task automatic redirectTo(input logic [31:0] target);
        redirectValid = 1'b1;
        redirectPc    = target;
        @(negedge clk);
        total++;
        if (instrValid !== 1'b0 || fetchReady !== 1'b0) begin
            bad++;
            $display("FAIL redirect_block: instrValid=%b fetchReady=%b, required 0 0", instrValid, fetchReady);
        end
        @(posedge clk);
        #1;
        redirectValid = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0; fetchValid = 1'b0; fetchWord = '0;
        redirectValid = 1'b0; redirectPc = '0; instrReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (instrValid !== 1'b0 || instr !== 32'h0 || instrPc !== RST_PC || fetchReady !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: valid=%b instr=%h pc=%h ready=%b, required 0 00000000 %h 1",
                     instrValid, instr, instrPc, fetchReady, RST_PC);
        end
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        xferLog.delete();
        pushExp(32'h00A00093, 32'h0);
        pushExp(32'h00108113, 32'h4);
        pushExp(32'h00310193, 32'h8);
        sendWord(32'h00A00093);
        sendWord(32'h00108113);
        sendWord(32'h00310193);
        drain("back_to_back");
        total++;
        if (xferLog.size() != 3 || xferLog[1] != xferLog[0] + 1 || xferLog[2] != xferLog[1] + 1) begin
            bad++;
            $display("FAIL back_to_back_rate: %0d transfers not on consecutive cycles, required 3 consecutive",
                     xferLog.size());
        end
    endtask

`ifdef ALIGNER_COMPRESSED_EN
    task automatic test_compressed_pair();
        redirectTo(32'h0);
        xferLog.delete();
        pushExp(32'h00004505, 32'h0);
        pushExp(32'h00004501, 32'h2);
        sendWord(32'h45014505);
        drain("compressed_pair");
        total++;
        if (xferLog.size() != 2 || xferLog[1] != xferLog[0] + 1) begin
            bad++;
            $display("FAIL compressed_pair_rate: %0d transfers, required 2 consecutive", xferLog.size());
        end
    endtask

    task automatic test_straddle();
        redirectTo(32'h0);
        pushExp(32'h00004505, 32'h0);
        pushExp(32'h00A00093, 32'h2);
        pushExp(32'h00000000, 32'h6);
        sendWord(32'h00934505);
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (instrValid !== 1'b0 || expQ.size() != 2 || fetchReady !== 1'b1) begin
            bad++;
            $display("FAIL straddle_wait: valid=%b pending=%0d ready=%b, required 0 2 1",
                     instrValid, expQ.size(), fetchReady);
        end
        @(posedge clk);
        #1;
        sendWord(32'h000000A0);
        drain("straddle");
    endtask
`endif

    task automatic test_redirect_skip();
        redirectTo(32'h00000102);
`ifdef ALIGNER_COMPRESSED_EN
        pushExp(32'h00004581, 32'h00000102);
`else
        pushExp(32'h45811234, 32'h00000100);
`endif
        sendWord(32'h45811234);
        drain("redirect_skip");
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (instrValid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_skip_extra: instrValid=%b, required 0", instrValid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        redirectTo(32'h00000300);
        pushExp(32'h00A00093, 32'h300);
        pushExp(32'h00108113, 32'h304);
        instrReady = 1'b0;
        sendWord(32'h00A00093);
        fork
            sendWord(32'h00108113);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    total++;
                    if (instrValid !== 1'b1 || instr !== 32'h00A00093 || instrPc !== 32'h300 || fetchReady !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_hold: valid=%b instr=%h pc=%h ready=%b, required 1 00a00093 00000300 0",
                                 instrValid, instr, instrPc, fetchReady);
                    end
                end
                @(posedge clk);
                #1;
                instrReady = 1'b1;
            end
        join
        drain("stall");
    endtask

    task automatic test_redirect_collision();
        redirectTo(32'h00000200);
        sendWord(32'h00310193);
        // Word now buffered and would transfer; collide redirect with fetch and transfer.
        redirectValid = 1'b1;
        redirectPc    = 32'h00000200;
        fetchValid    = 1'b1;
        fetchWord     = 32'h00108113;
        @(negedge clk);
        total++;
        if (instrValid !== 1'b0 || fetchReady !== 1'b0) begin
            bad++;
            $display("FAIL collision_block: valid=%b ready=%b, required 0 0", instrValid, fetchReady);
        end
        @(posedge clk);
        #1;
        redirectValid = 1'b0;
        fetchValid    = 1'b0;
        @(negedge clk);
        total++;
        if (instrValid !== 1'b0 || instrPc !== 32'h200) begin
            bad++;
            $display("FAIL collision_flush: valid=%b pc=%h, required 0 00000200", instrValid, instrPc);
        end
        @(posedge clk);
        #1;
        pushExp(32'h00A00093, 32'h200);
        sendWord(32'h00A00093);
        drain("collision");
    endtask

    task automatic test_mid_reset();
        instrReady = 1'b0;
        sendWord(32'h00A00093);
        #3;
        rstN = 1'b0;
        #1;
        total++;
        if (instrValid !== 1'b0 || instrPc !== RST_PC || fetchReady !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: valid=%b pc=%h ready=%b, required 0 %h 1", instrValid, instrPc, fetchReady, RST_PC);
        end
        @(posedge clk);
        #1;
        rstN = 1'b1;
        instrReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
`ifdef ALIGNER_COMPRESSED_EN
        test_compressed_pair();
        test_straddle();
`endif
        test_redirect_skip();
        test_stall();
        test_redirect_collision();
        test_mid_reset();
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL final_queue: %0d pending, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
